exe_stage: RTL
==============

# exe_stage

Execute stage of the 5-stage ARM pipeline. It consumes the decoded fields from the ID/EXE pipeline register and selects forwarded operands. It generates the second operand (Val2), runs the ALU and computes the branch target. It owns the NZCV status register and registers its results into the EXE/MEM boundary for the memory stage.

## Interface
Parameters:
- none; widths fixed (32-bit datapath, 4-bit register index).

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- freeze  in  1  memory-stage stall; holds all state
- WB_EN, MEM_R_EN, MEM_W_EN, B, S, imm  in  1 each  decoded control from ID/EXE
- EXE_CMD  in  4  ALU opcode
- PC  in  32  PC value carried with the instruction
- Val_Rn, Val_Rm  in  32  register-file operands
- Shift_operand  in  12  shifter/immediate field
- Signed_imm_24  in  24  branch offset
- Dest  in  4  destination register
- sel_src1, sel_src2  in  2  forwarding select: 00 register file, 01 MEM ALU_result, 10 WB value, 11 reserved (treat as 00)
- MEM_fwd, WB_fwd  in  32  forwarded values
- Br_taken  out  1  equals B, combinational
- Br_addr  out  32  branch target, combinational
- status  out  4  registered {N,Z,C,V}
- WB_EN_OUT, MEM_R_EN_OUT, MEM_W_EN_OUT  out  1  registered
- ALU_result  out  32  registered
- ST_val  out  32  registered forwarded Val_Rm, used as store data
- Dest_OUT  out  4  registered

## Operation
- Operand A is Val_Rn or a forwarded value per sel_src1. Rm_f is Val_Rm or a forwarded value per sel_src2.
- Val2 is computed as follows, in priority order:
  - imm=1: {24'b0, Shift_operand[7:0]} rotated right by 2*Shift_operand[11:8].
  - MEM_R_EN or MEM_W_EN: {20'b0, Shift_operand[11:0]}.
  - Otherwise: Rm_f shifted by Shift_operand[11:7]. Type Shift_operand[6:5] selects 00 LSL, 01 LSR, 10 ASR, 11 ROR. A shift amount of 0 passes Rm_f unchanged.
- EXE_CMD encodings:
  - 0001 MOV: Val2
  - 1001 MVN: ~Val2
  - 0010 ADD/LDR/STR: A+Val2
  - 0011 ADC: A+Val2+C
  - 0100 SUB/CMP: A-Val2
  - 0101 SBC: A-Val2-!C
  - 0110 AND/TST: A&Val2
  - 0111 ORR
  - 1000 EOR
  - Any other code: result 0, flags unchanged.
- Arithmetic uses a 33-bit sum. For subtraction, C = carry-out of A + ~Val2 + 1 (ARM not-borrow). V = signed overflow of the 32-bit operation.
- Logical ops and MOV/MVN set N and Z only; C and V are kept.
- N = result[31]. Z = (result == 0).
- Br_addr = PC + {{6{Signed_imm_24[23]}}, Signed_imm_24, 2'b00}, wrapping modulo 2^32.

## Timing
- Reset (rst low, asynchronous): status=0000, ALU_result=0, ST_val=0, Dest_OUT=0, all *_OUT enables 0.
- On a rising edge with freeze=0:
  - The EXE/MEM outputs capture this cycle's results, giving 1-cycle latency.
  - status captures the new flags only if S=1; otherwise it holds.
- freeze=1 holds every register regardless of S.
- The freeze input has no effect while rst is low.
- Br_taken and Br_addr are combinational in the same cycle and are not gated by freeze.
- status is visible to ID condition evaluation in the cycle after the edge that updates it. There is no internal bypass.
- ADC/SBC use the registered C, i.e. the value before this instruction.

## Structure
- Shared package arm_defs:
  - EXE_CMD localparams
  - shift-type codes
  - forwarding-select codes
  - status bit indices N=3, Z=2, C=1, V=0
- One sub-module, val2_generator (combinational), takes Rm_f, Shift_operand, imm and mem_access, and returns Val2.
- ALU, status register and EXE/MEM register stay inline.

## Test plan
- Reset then ADD: A=5, imm=1, Shift_operand=12'h003, S=1, cycle 1. Required: ALU_result=8 at cycle 2, status=0000.
- SUB with S=1: A=3, Val2=3. Required: ALU_result=0, status Z=1, C=1, i.e. 0110. A following ADC 1+1 with S=0 gives 3, and status stays 0110.
- Immediate rotate: Shift_operand=12'h1FF. Required: Val2=32'hC000003F. With EXE_CMD=MOV, ALU_result=C000003F.
- Register shift: Rm=32'h8000_0000, shift ASR by 4. Required: 32'hF800_0000. The same operand with ROR by 1 gives 32'h4000_0000.
- Forwarding and freeze:
  - sel_src1=01, MEM_fwd=100, Val_Rn=7, ADD with Val2=1. Required: ALU_result=101.
  - Assert freeze for 2 cycles with new inputs. Required: outputs and status hold.
- Branch: PC=32'h100, Signed_imm_24=24'hFFFFFE. Required: Br_addr=32'hF8, Br_taken=1 in the same cycle.

Source files
------------

// File: rtl/arm_defs_pkg.sv
//==============================================================================
// arm_defs : shared constants for the ARM execute stage (ALU opcodes,
//            shift types, forwarding selects, status bit positions).
// Rev 1.0
//==============================================================================
`default_nettype none

package arm_defs;

  localparam logic [3:0] c_EXE_MOV = 4'b0001;
  localparam logic [3:0] c_EXE_MVN = 4'b1001;
  localparam logic [3:0] c_EXE_ADD = 4'b0010;
  localparam logic [3:0] c_EXE_ADC = 4'b0011;
  localparam logic [3:0] c_EXE_SUB = 4'b0100;
  localparam logic [3:0] c_EXE_SBC = 4'b0101;
  localparam logic [3:0] c_EXE_AND = 4'b0110;
  localparam logic [3:0] c_EXE_ORR = 4'b0111;
  localparam logic [3:0] c_EXE_EOR = 4'b1000;

  localparam logic [1:0] c_SHIFT_LSL = 2'b00;
  localparam logic [1:0] c_SHIFT_LSR = 2'b01;
  localparam logic [1:0] c_SHIFT_ASR = 2'b10;
  localparam logic [1:0] c_SHIFT_ROR = 2'b11;

  localparam logic [1:0] c_FWD_RF  = 2'b00;
  localparam logic [1:0] c_FWD_MEM = 2'b01;
  localparam logic [1:0] c_FWD_WB  = 2'b10;

  localparam int c_N_IDX = 3;
  localparam int c_Z_IDX = 2;
  localparam int c_C_IDX = 1;
  localparam int c_V_IDX = 0;

  // The reserved select 2'b11 falls back to the register-file value.
  function automatic logic [31:0] fwd_select(input logic [1:0]  sel,
                                             input logic [31:0] rf,
                                             input logic [31:0] mem,
                                             input logic [31:0] wb);
    case (sel)
      c_FWD_MEM: fwd_select = mem;
      c_FWD_WB:  fwd_select = wb;
      default:   fwd_select = rf;
    endcase
  endfunction

  function automatic logic [31:0] ror32(input logic [31:0] x,
                                        input logic [4:0]  amt);
    ror32 = (x >> amt) | (x << (6'd32 - {1'b0, amt}));
  endfunction

endpackage

`default_nettype wire

// File: rtl/exe_stage_val2_generator.sv
//==============================================================================
// val2_generator : builds the ALU second operand from the rotated immediate,
//                  the raw memory offset, or the shifted register operand.
// Rev 1.0
//==============================================================================
`default_nettype none

module val2_generator
  import arm_defs::*;
(
  input  logic [31:0] i_rm_f,
  input  logic [11:0] i_shift_operand,
  input  logic        i_imm,
  input  logic        i_mem_access,
  output logic [31:0] o_val2
);

  logic [4:0]  w_rot_amt;
  logic [4:0]  w_sh_amt;
  logic [31:0] w_shifted;

  assign w_rot_amt = {i_shift_operand[11:8], 1'b0};
  assign w_sh_amt  = i_shift_operand[11:7];

  always_comb begin
    w_shifted = i_rm_f;
    case (i_shift_operand[6:5])
      c_SHIFT_LSL: w_shifted = i_rm_f << w_sh_amt;
      c_SHIFT_LSR: w_shifted = i_rm_f >> w_sh_amt;
      c_SHIFT_ASR: w_shifted = $signed(i_rm_f) >>> w_sh_amt;
      default:     w_shifted = ror32(i_rm_f, w_sh_amt);
    endcase
  end

  always_comb begin
    o_val2 = w_shifted;
    if (i_imm)
      o_val2 = ror32({24'b0, i_shift_operand[7:0]}, w_rot_amt);
    else if (i_mem_access)
      o_val2 = {20'b0, i_shift_operand};
  end

endmodule

`default_nettype wire

// File: rtl/exe_stage.sv
//==============================================================================
// exe_stage : ARM pipeline execute stage - operand forwarding, ALU, NZCV
//             status register, branch target and EXE/MEM register.
// Rev 1.0
//==============================================================================
`default_nettype none

module exe_stage
  import arm_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        WB_EN,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic        B,
  input  logic        S,
  input  logic        imm,
  input  logic [3:0]  EXE_CMD,
  input  logic [31:0] PC,
  input  logic [31:0] Val_Rn,
  input  logic [31:0] Val_Rm,
  input  logic [11:0] Shift_operand,
  input  logic [23:0] Signed_imm_24,
  input  logic [3:0]  Dest,
  input  logic [1:0]  sel_src1,
  input  logic [1:0]  sel_src2,
  input  logic [31:0] MEM_fwd,
  input  logic [31:0] WB_fwd,
  output logic        Br_taken,
  output logic [31:0] Br_addr,
  output logic [3:0]  status,
  output logic        WB_EN_OUT,
  output logic        MEM_R_EN_OUT,
  output logic        MEM_W_EN_OUT,
  output logic [31:0] ALU_result,
  output logic [31:0] ST_val,
  output logic [3:0]  Dest_OUT
);

  logic [31:0] w_a;
  logic [31:0] w_rm_f;
  logic [31:0] w_val2;
  logic [32:0] w_sum;
  logic [31:0] w_result;
  logic [3:0]  w_flags;
  logic        w_c_in;
  logic        w_b_msb;

  logic [3:0]  r_status;
  logic [31:0] r_alu_result;
  logic [31:0] r_st_val;
  logic [3:0]  r_dest;
  logic        r_wb_en;
  logic        r_mem_r_en;
  logic        r_mem_w_en;

  assign w_a    = fwd_select(sel_src1, Val_Rn, MEM_fwd, WB_fwd);
  assign w_rm_f = fwd_select(sel_src2, Val_Rm, MEM_fwd, WB_fwd);
  assign w_c_in = r_status[c_C_IDX];

  val2_generator u_val2 (
    .i_rm_f          (w_rm_f),
    .i_shift_operand (Shift_operand),
    .i_imm           (imm),
    .i_mem_access    (MEM_R_EN | MEM_W_EN),
    .o_val2          (w_val2)
  );

  // Subtractions run as A + ~Val2 + cin so C is the ARM not-borrow and the
  // overflow test is shared with addition via w_b_msb.
  always_comb begin
    w_sum    = 33'd0;
    w_result = 32'd0;
    w_flags  = r_status;
    w_b_msb  = w_val2[31];
    case (EXE_CMD)
      c_EXE_ADD: w_sum = {1'b0, w_a} + {1'b0, w_val2};
      c_EXE_ADC: w_sum = {1'b0, w_a} + {1'b0, w_val2} + {32'd0, w_c_in};
      c_EXE_SUB: begin
        w_sum   = {1'b0, w_a} + {1'b0, ~w_val2} + 33'd1;
        w_b_msb = ~w_val2[31];
      end
      c_EXE_SBC: begin
        w_sum   = {1'b0, w_a} + {1'b0, ~w_val2} + {32'd0, w_c_in};
        w_b_msb = ~w_val2[31];
      end
      default: w_sum = 33'd0;
    endcase

    case (EXE_CMD)
      c_EXE_ADD, c_EXE_ADC, c_EXE_SUB, c_EXE_SBC: begin
        w_result         = w_sum[31:0];
        w_flags[c_N_IDX] = w_result[31];
        w_flags[c_Z_IDX] = (w_result == 32'd0);
        w_flags[c_C_IDX] = w_sum[32];
        w_flags[c_V_IDX] = (w_a[31] == w_b_msb) && (w_result[31] != w_a[31]);
      end
      c_EXE_MOV, c_EXE_MVN, c_EXE_AND, c_EXE_ORR, c_EXE_EOR: begin
        case (EXE_CMD)
          c_EXE_MOV: w_result = w_val2;
          c_EXE_MVN: w_result = ~w_val2;
          c_EXE_AND: w_result = w_a & w_val2;
          c_EXE_ORR: w_result = w_a | w_val2;
          default:   w_result = w_a ^ w_val2;
        endcase
        w_flags[c_N_IDX] = w_result[31];
        w_flags[c_Z_IDX] = (w_result == 32'd0);
      end
      default: begin
        w_result = 32'd0;
        w_flags  = r_status;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_status     <= 4'd0;
      r_alu_result <= 32'd0;
      r_st_val     <= 32'd0;
      r_dest       <= 4'd0;
      r_wb_en      <= 1'b0;
      r_mem_r_en   <= 1'b0;
      r_mem_w_en   <= 1'b0;
    end else if (!freeze) begin
      r_alu_result <= w_result;
      r_st_val     <= w_rm_f;
      r_dest       <= Dest;
      r_wb_en      <= WB_EN;
      r_mem_r_en   <= MEM_R_EN;
      r_mem_w_en   <= MEM_W_EN;
      if (S)
        r_status <= w_flags;
    end
  end

  assign Br_taken     = B;
  assign Br_addr      = PC + {{6{Signed_imm_24[23]}}, Signed_imm_24, 2'b00};
  assign status       = r_status;
  assign ALU_result   = r_alu_result;
  assign ST_val       = r_st_val;
  assign Dest_OUT     = r_dest;
  assign WB_EN_OUT    = r_wb_en;
  assign MEM_R_EN_OUT = r_mem_r_en;
  assign MEM_W_EN_OUT = r_mem_w_en;

endmodule

`default_nettype wire
